pwm_duty_sched: RTL
===================

# pwm_duty_sched

Duty-cycle scheduler for the three-channel PWM block. Holds a target and a current duty per channel, ramps each current duty toward its target in programmable steps at a programmable rate, and arbitrates between host "force" writes and ramp updates onto the single duty write port (`duty_wr`/`duty_ch`/`duty_val`) of the PWM datapath. It sits between the host/button logic and the PWM duty register file, which feeds `d0`..`d2`.

## Interface
- `DUTY_W`, 8, duty width (counter period 2^DUTY_W)
- `NCH`, 3, channel count (≤ 4)
- `RATE_W`, 16, prescaler width

- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `set_wr`  in  1  load target for `set_ch` from `set_val`; the channel ramps to it
- `set_ch`  in  2  channel for `set_wr`
- `set_val`  in  DUTY_W  target duty
- `force_wr`  in  1  immediate write; sets current and target, bypassing the ramp
- `force_ch`  in  2  channel for `force_wr`
- `force_val`  in  DUTY_W  forced duty
- `rate`  in  RATE_W  cycles between ramp ticks minus 1
- `step`  in  DUTY_W  ramp increment per tick; 0 means hold
- `duty_wr`  out  1  one-cycle write strobe to the PWM duty registers
- `duty_ch`  out  2  channel written
- `duty_val`  out  DUTY_W  value written
- `cur_duty`  out  NCH*DUTY_W  packed current duties, ch0 in the LSBs
- `busy`  out  1  any pending bit set, or any current ≠ target

## Operation
- **State per channel:** `tgt[i]` and `cur[i]`, both reset to 0; `pend[NCH]` reset to 0. Round-robin pointer `rr` resets to 0.
- **Prescaler:** `presc` resets to 0.
  - When `presc == rate`: `presc <= 0` (tick).
  - Otherwise: `presc++`.
  - `rate = 0` gives a tick every cycle.
- **On a tick:** `pend[i] <= pend[i] | (cur[i] != tgt[i] && step != 0)`, using registered values. A bit that is already set stays set; there is no double step.
- **Target writes:** `set_wr` with `set_ch < NCH` gives `tgt[set_ch] <= set_val`. A channel index ≥ NCH is ignored.
- **Arbitration:** one write per cycle.
  - **Priority 1, `force_wr` with a valid channel:**
    - `cur` and `tgt` of `force_ch` are set to `force_val`.
    - `pend[force_ch]` is cleared.
    - A duty write is emitted.
    - Force beats `set_wr` to the same channel in the same cycle.
  - **Priority 2, ramp:**
    - Choose the first set `pend` bit, searching from `rr` upward with wrap.
    - Clear that bit and set `rr <= ch+1` (mod NCH).
    - If `cur == tgt` at grant, skip: the bit is cleared and no write is emitted.
    - Otherwise compute `nxt`:
      - `cur < tgt`: `cur + min(step, tgt-cur)`.
      - `cur > tgt`: `cur - min(step, cur-tgt)`.
    - Use DUTY_W+1-bit differences, so the result never overshoots or wraps.
    - Update `cur <= nxt` and emit a write with `nxt`.
  - **Tick and grant on the same edge:** the tick OR-sets after the grant clear, so the tick wins and the channel is re-evaluated later.
- **Conditional state machine:** IDLE (`pend == 0`) → GRANT (`pend != 0`, no valid force) → IDLE when `pend` drains. Force is serviced from either state.

## Timing
- **Registered outputs:** all outputs are registered.
- **Reset values:** `duty_wr = 0`, `duty_ch = 0`, `duty_val = 0`, `cur_duty = 0`, `busy = 0`.
- **Force latency:** `force_wr` sampled at edge N gives `duty_wr = 1` with `force_val` after edge N. `cur_duty` updates on the same edge.
- **Ramp latency:** the tick sets `pend` at edge E; the first ramp write is visible after edge E+1.
- **Back-to-back writes:** channels with pending bits are written on consecutive cycles, round-robin.
- **Stalls:** a `force_wr` stalls the ramp by exactly one cycle; `rr` is unchanged.
- **Parameter changes:** changing `rate` mid-count takes effect on the next comparison. If `presc > rate`, the counter runs to wrap: it counts to all-ones, wraps to 0, then ticks at the new `rate`.
- **Reset mid-ramp:** `rst` clears all state in one cycle, with no trailing write.

## Structure
- **Shared package `pwm_pkg`:** `DUTY_W`, `NCH`, `CH_W = 2`, and a helper function `ramp_next(cur, tgt, step)`. The package is shared with the PWM datapath.
- **Sub-module `ramp_tick_gen`:** contains the prescaler, with ports `clk`, `rst`, `rate`, and `tick`.
- **Top level:** the arbiter, the `pend`/`rr` logic, and the register arrays stay in `pwm_duty_sched`.

## Test plan
- **Up ramp:** `rate = 3`, `step = 16`, `set` ch0 = 64. Expect writes ch0 = 16, 32, 48, 64, spaced 4 cycles apart, then `busy = 0`.
- **Down ramp, non-multiple:**
  - Setup: force ch1 = 64, then `set` ch1 = 10, `step = 16`.
  - Expect writes 48, 32, 16, 10, with no underflow.
- **Round-robin:** `rate = 0`, `step = 255`, `set` ch0 = 10, ch1 = 20, ch2 = 30 before the first tick. Expect writes ch0, ch1, ch2 on consecutive cycles with those values.
- **Force preemption and invalid channel:**
  - `force_wr` ch1 = 192 during an active ramp: `duty_wr` ch1 = 192 next cycle, and the ramp resumes one cycle later on the same `rr`.
  - `force_ch = 3`: ignored, no write.
- **Hold:** `step = 0` with ch2 target 128 ≠ current 0: no writes, `busy = 1` held.
- **Reset mid-ramp:** assert `rst` after the second write of the ramp to 64. Expect all outputs 0 next cycle, and no write for at least `rate + 1` cycles afterward.

Source files
------------

// File: rtl/pwm_pkg.sv
// ---------------------------------------------------------------------------
// pwm_pkg
// Shared definitions for the three-channel PWM block: duty width, channel
// count, channel index width, the scheduler state type and the ramp step
// helper used to move a current duty one step toward its target.
// Ports: none (package).
// ---------------------------------------------------------------------------
package pwm_pkg;

   localparam int DUTY_W = 8;
   localparam int NCH    = 3;
   localparam int CH_W   = 2;

   typedef enum logic {
      SCHED_IDLE,
      SCHED_GRANT
   } schedState_e;

   // One ramp step from cur toward tgt. The distance is taken one bit wider
   // than the duty so the step is clamped to the remaining distance and the
   // result can never overshoot the target or wrap around zero/full scale.
   function automatic logic [DUTY_W-1:0] ramp_next(
      input logic [DUTY_W-1:0] cur,
      input logic [DUTY_W-1:0] tgt,
      input logic [DUTY_W-1:0] step
   );
      logic [DUTY_W:0]   diff;
      logic [DUTY_W-1:0] nxt;
      diff = '0;
      nxt  = cur;
      if (cur < tgt) begin
         diff = {1'b0, tgt} - {1'b0, cur};
         if ({1'b0, step} < diff) nxt = cur + step;
         else                     nxt = tgt;
      end else if (cur > tgt) begin
         diff = {1'b0, cur} - {1'b0, tgt};
         if ({1'b0, step} < diff) nxt = cur - step;
         else                     nxt = tgt;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/ramp_tick_gen.sv
// ---------------------------------------------------------------------------
// ramp_tick_gen
// Prescaler producing the ramp tick. The counter runs 0..rate and the tick is
// asserted in the cycle the counter equals rate, so rate = 0 ticks every
// cycle. If rate is lowered below the current count, the counter simply keeps
// counting, wraps through all-ones to 0 and then ticks at the new rate.
// Ports:
//   clk   in   system clock
//   rst   in   synchronous active-high reset
//   rate  in   cycles between ticks minus 1
//   tick  out  ramp tick (combinational from the registered count)
// ---------------------------------------------------------------------------
module ramp_tick_gen #(
   parameter int unsigned RATE_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [RATE_W-1:0] rate,
   output logic              tick
);

   logic [RATE_W-1:0] presc_q;
   logic [RATE_W-1:0] presc_d;

   // Tick when the count reaches rate, then restart from zero.
   always_comb begin
      tick    = (presc_q == rate);
      presc_d = tick ? '0 : presc_q + 1'b1;
   end

   // Prescaler count register.
   always_ff @(posedge clk) begin
      if (rst) presc_q <= '0;
      else     presc_q <= presc_d;
   end

endmodule

// File: rtl/pwm_duty_sched.sv
// ---------------------------------------------------------------------------
// pwm_duty_sched
// Duty-cycle scheduler for the PWM block. Keeps a target and a current duty
// per channel, ramps current toward target in steps on each prescaler tick
// and arbitrates host force writes against ramp updates onto the single duty
// write port. Force writes always win; ramp writes are granted round-robin.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   set_wr/set_ch/set_val         load a new target (channel ramps to it)
//   force_wr/force_ch/force_val   immediate write of current and target
//   rate                          ramp tick period minus 1
//   step                          ramp increment per tick, 0 holds
//   duty_wr/duty_ch/duty_val      registered write strobe to the duty regs
//   cur_duty                      packed current duties, ch0 in the LSBs
//   busy                          pending ramp work or any current != target
// ---------------------------------------------------------------------------
module pwm_duty_sched
   import pwm_pkg::*;
#(
   parameter int unsigned RATE_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  set_wr,
   input  logic [CH_W-1:0]       set_ch,
   input  logic [DUTY_W-1:0]     set_val,
   input  logic                  force_wr,
   input  logic [CH_W-1:0]       force_ch,
   input  logic [DUTY_W-1:0]     force_val,
   input  logic [RATE_W-1:0]     rate,
   input  logic [DUTY_W-1:0]     step,
   output logic                  duty_wr,
   output logic [CH_W-1:0]       duty_ch,
   output logic [DUTY_W-1:0]     duty_val,
   output logic [NCH*DUTY_W-1:0] cur_duty,
   output logic                  busy
);

   logic [DUTY_W-1:0] curDuty_q [NCH];
   logic [DUTY_W-1:0] curDuty_d [NCH];
   logic [DUTY_W-1:0] tgtDuty_q [NCH];
   logic [DUTY_W-1:0] tgtDuty_d [NCH];
   logic [NCH-1:0]    pend_q;
   logic [NCH-1:0]    pend_d;
   logic [CH_W-1:0]   rrPtr_q;
   logic [CH_W-1:0]   rrPtr_d;
   schedState_e       state_q;
   schedState_e       state_d;
   logic              dutyWr_q;
   logic              dutyWr_d;
   logic [CH_W-1:0]   dutyCh_q;
   logic [CH_W-1:0]   dutyCh_d;
   logic [DUTY_W-1:0] dutyVal_q;
   logic [DUTY_W-1:0] dutyVal_d;
   logic              busy_q;
   logic              busy_d;

   logic              tick;
   logic              forceValid;
   logic              setValid;
   logic              grantFound;
   logic [CH_W-1:0]   grantCh;
   logic [CH_W:0]     probe;
   logic [DUTY_W-1:0] rampVal;

   ramp_tick_gen #(
      .RATE_W (RATE_W)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .rate (rate),
      .tick (tick)
   );

   // Channel indices beyond NCH are silently dropped. The compare is done one
   // bit wider so it still works when NCH fills the whole index range.
   always_comb begin
      forceValid = force_wr && ({1'b0, force_ch} < (CH_W+1)'(NCH));
      setValid   = set_wr   && ({1'b0, set_ch}   < (CH_W+1)'(NCH));
   end

   // Round-robin search: first pending channel at or after rrPtr, wrapping
   // at NCH rather than at the power of two.
   always_comb begin
      grantFound = 1'b0;
      grantCh    = '0;
      probe      = '0;
      for (int k = 0; k < NCH; k++) begin
         probe = {1'b0, rrPtr_q} + (CH_W+1)'(k);
         if (probe >= (CH_W+1)'(NCH)) probe = probe - (CH_W+1)'(NCH);
         if (!grantFound && pend_q[probe[CH_W-1:0]]) begin
            grantFound = 1'b1;
            grantCh    = probe[CH_W-1:0];
         end
      end
      rampVal = ramp_next(curDuty_q[grantCh], tgtDuty_q[grantCh], step);
   end

   // Next-state logic. Order matters: target writes first so a force to the
   // same channel overrides them, then force-or-grant, and finally the tick
   // OR-sets pending bits after any clear so a tick landing on the grant edge
   // re-queues the channel instead of being lost.
   always_comb begin
      curDuty_d = curDuty_q;
      tgtDuty_d = tgtDuty_q;
      pend_d    = pend_q;
      rrPtr_d   = rrPtr_q;
      dutyWr_d  = 1'b0;
      dutyCh_d  = dutyCh_q;
      dutyVal_d = dutyVal_q;
      busy_d    = 1'b0;

      if (setValid) tgtDuty_d[set_ch] = set_val;

      if (forceValid) begin
         curDuty_d[force_ch] = force_val;
         tgtDuty_d[force_ch] = force_val;
         pend_d[force_ch]    = 1'b0;
         dutyWr_d            = 1'b1;
         dutyCh_d            = force_ch;
         dutyVal_d           = force_val;
      end else if (state_q == SCHED_GRANT && grantFound) begin
         pend_d[grantCh] = 1'b0;
         rrPtr_d = (grantCh == CH_W'(NCH - 1)) ? '0 : grantCh + 1'b1;
         // A channel that already reached its target is just retired.
         if (curDuty_q[grantCh] != tgtDuty_q[grantCh]) begin
            curDuty_d[grantCh] = rampVal;
            dutyWr_d           = 1'b1;
            dutyCh_d           = grantCh;
            dutyVal_d          = rampVal;
         end
      end

      if (tick) begin
         for (int i = 0; i < NCH; i++) begin
            pend_d[i] = pend_d[i] | ((curDuty_q[i] != tgtDuty_q[i]) && (step != '0));
         end
      end

      state_d = (pend_d != '0) ? SCHED_GRANT : SCHED_IDLE;

      busy_d = (pend_d != '0);
      for (int i = 0; i < NCH; i++) begin
         if (curDuty_d[i] != tgtDuty_d[i]) busy_d = 1'b1;
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NCH; i++) begin
            curDuty_q[i] <= '0;
            tgtDuty_q[i] <= '0;
         end
         pend_q    <= '0;
         rrPtr_q   <= '0;
         state_q   <= SCHED_IDLE;
         dutyWr_q  <= 1'b0;
         dutyCh_q  <= '0;
         dutyVal_q <= '0;
         busy_q    <= 1'b0;
      end else begin
         curDuty_q <= curDuty_d;
         tgtDuty_q <= tgtDuty_d;
         pend_q    <= pend_d;
         rrPtr_q   <= rrPtr_d;
         state_q   <= state_d;
         dutyWr_q  <= dutyWr_d;
         dutyCh_q  <= dutyCh_d;
         dutyVal_q <= dutyVal_d;
         busy_q    <= busy_d;
      end
   end

   // Current duties are exported straight from the registers, packed.
   always_comb begin
      cur_duty = '0;
      for (int i = 0; i < NCH; i++) begin
         cur_duty[i*DUTY_W +: DUTY_W] = curDuty_q[i];
      end
   end

   assign duty_wr  = dutyWr_q;
   assign duty_ch  = dutyCh_q;
   assign duty_val = dutyVal_q;
   assign busy     = busy_q;

endmodule
